// File: rtl/bus8088_pkg.sv
// ---------------------------------------------------------------------------
// bus8088_pkg
//   Shared definitions for 8088 minimum-mode bus slave models.
//   - bus_state_t : bus-cycle sequencing states of a slave device
//   - MEM_DEV/IO_DEV : device-type selectors (which IOM polarity we answer)
//   - addr20_t    : 20-bit demultiplexed 8088 address
//   - dev_selected() : does a cycle's IOM value address this device type
// ---------------------------------------------------------------------------
package bus8088_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    RDATA,
    WDATA,
    DONE
  } bus_state_t;

  localparam int MEM_DEV = 0;
  localparam int IO_DEV  = 1;

  typedef logic [19:0] addr20_t;

  // A memory device answers IOM=1 cycles, an I/O device answers IOM=0.
  function automatic logic dev_selected(input logic iom, input int io);
    return iom == (io == MEM_DEV);
  endfunction

endpackage

// File: rtl/bus_slave_fsm_wait_state_counter.sv
// ---------------------------------------------------------------------------
// wait_state_counter
//   Loadable 4-bit down-counter that paces the Tw states of a bus access.
//   The zero flag is a pure function of the count register, so anything
//   derived from it (READY) only changes on a clock edge or on reset.
//
// Ports:
//   CLK        in  bus clock, posedge
//   RESET_N    in  asynchronous active-low reset (count -> 0)
//   load       in  load load_value on the next edge
//   load_value in  [3:0] number of wait states to insert
//   dec        in  decrement on the next edge (saturates at 0)
//   clear      in  force count to 0 on the next edge (highest priority)
//   count      out [3:0] current count
//   zero       out count == 0
// ---------------------------------------------------------------------------
module wait_state_counter (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  input  logic       clear,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_reg;
  logic [3:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = 4'd0;
    end else if (load) begin
      count_next = load_value;
    end else if (dec && (count_reg != 4'd0)) begin
      count_next = count_reg - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_reg <= 4'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == 4'd0);

endmodule

// File: rtl/bus_slave_fsm.sv
// ---------------------------------------------------------------------------
// bus_slave_fsm
//   Cycle-accurate 8088 minimum-mode bus slave sitting behind the address
//   latch and data transceiver. Decodes ALE/IOM/RD/WR/CS, inserts
//   WAIT_STATES Tw cycles by holding READY low, and services byte reads and
//   writes to a 2**ADDR_BITS byte internal store. Storage has no reset so
//   its contents survive RESET_N.
//
// Parameters:
//   IO          0 = memory device (IOM=1 cycles), 1 = I/O device (IOM=0)
//   ADDR_BITS   storage depth is 2**ADDR_BITS bytes
//   WAIT_STATES Tw cycles inserted per access (0..15)
//
// Ports:
//   CLK       in    bus clock, everything sampled on posedge
//   RESET_N   in    asynchronous active-low reset
//   CS        in    chip select from external decode, active high
//   ALE       in    address latch enable
//   IOM       in    1 = memory cycle, 0 = I/O cycle
//   RD        in    read strobe, active low
//   WR        in    write strobe, active low
//   Address   in    [19:0] latched bus address
//   Data      inout [7:0] driven only in the read data phase, else 'z
//   READY     out   0 = insert wait state
//   PROTO_ERR out   one-cycle pulse on a protocol violation
// ---------------------------------------------------------------------------
module bus_slave_fsm
  import bus8088_pkg::*;
#(
  parameter int IO          = MEM_DEV,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CS,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD,
  input  logic        WR,
  input  logic [19:0] Address,
  inout  wire  [7:0]  Data,
  output logic        READY,
  output logic        PROTO_ERR
);

  localparam int         DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  bus_state_t           state_reg;
  bus_state_t           state_next;
  logic [ADDR_BITS-1:0] offset_reg;
  logic [ADDR_BITS-1:0] offset_next;
  logic                 write_dir_reg;   // 1 = current access is a write
  logic                 write_dir_next;
  logic                 proto_err_reg;
  logic                 proto_err_next;

  logic                 ctr_load;
  logic                 ctr_dec;
  logic                 ctr_clear;
  logic [3:0]           ctr_count;
  logic                 ctr_zero;

  logic                 mem_we;
  logic                 drive_data;
  logic                 selected;
  logic                 strobe_released;

  logic [7:0]           mem [DEPTH];

  // Only the low ADDR_BITS of the address index storage; the rest is
  // handled by the external CS decode.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^Address;

  assign selected = ALE && CS && dev_selected(IOM, IO);

  // During WAIT the strobe that started the access must stay asserted.
  assign strobe_released = write_dir_reg ? WR : RD;

  // -------------------------------------------------------------------------
  // Next-state / control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    offset_next    = offset_reg;
    write_dir_next = write_dir_reg;
    proto_err_next = 1'b0;
    ctr_load       = 1'b0;
    ctr_dec        = 1'b0;
    ctr_clear      = 1'b0;
    mem_we         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (selected) begin
          offset_next = Address[ADDR_BITS-1:0];
          state_next  = ADDR;
        end
      end

      ADDR: begin
        if (ALE) begin
          // A new address phase replaces the pending one; if it is not
          // ours any more, drop back to idle.
          if (selected) begin
            offset_next = Address[ADDR_BITS-1:0];
          end else begin
            state_next = IDLE;
          end
        end else if (!RD && !WR) begin
          proto_err_next = 1'b1;
          state_next     = IDLE;
        end else if (!RD || !WR) begin
          write_dir_next = !WR;
          if (WS_LOAD == 4'd0) begin
            state_next = !WR ? WDATA : RDATA;
          end else begin
            ctr_load   = 1'b1;
            state_next = WAIT;
          end
        end
      end

      WAIT: begin
        if (strobe_released) begin
          ctr_clear      = 1'b1;
          proto_err_next = 1'b1;
          state_next     = IDLE;
        end else begin
          ctr_dec = 1'b1;
          // Leaving on the edge that takes the count to zero makes READY
          // rise in the same cycle the data phase starts.
          if (ctr_count <= 4'd1) begin
            state_next = write_dir_reg ? WDATA : RDATA;
          end
        end
      end

      RDATA: begin
        if (RD) begin
          state_next = IDLE;
        end
      end

      WDATA: begin
        if (!WR) begin
          mem_we     = 1'b1;
          state_next = DONE;
        end else begin
          proto_err_next = 1'b1;
          state_next     = IDLE;
        end
      end

      DONE: begin
        if (WR) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // ALE in the middle of an access means the CPU has started a new bus
    // cycle under us: abandon this one and evaluate the new address phase
    // on the same edge.
    if (ALE && (state_reg != IDLE) && (state_reg != ADDR)) begin
      proto_err_next = 1'b1;
      ctr_clear      = 1'b1;
      ctr_dec        = 1'b0;
      mem_we         = 1'b0;
      if (selected) begin
        offset_next = Address[ADDR_BITS-1:0];
        state_next  = ADDR;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      offset_reg    <= '0;
      write_dir_reg <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      offset_reg    <= offset_next;
      write_dir_reg <= write_dir_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Wait-state pacing; READY is high whenever no Tw is pending
  // -------------------------------------------------------------------------
  wait_state_counter u_wait_ctr (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .load       (ctr_load),
    .load_value (WS_LOAD),
    .dec        (ctr_dec),
    .clear      (ctr_clear),
    .count      (ctr_count),
    .zero       (ctr_zero)
  );

  // -------------------------------------------------------------------------
  // Byte storage: no reset, contents persist across RESET_N
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[offset_reg] <= Data;
    end
  end

  // Read data follows RD combinationally so the bus is released as soon as
  // the CPU lifts the strobe, and immediately on an async reset.
  assign drive_data = (state_reg == RDATA) && !RD;
  assign Data       = drive_data ? mem[offset_reg] : 8'hzz;

  assign READY     = ctr_zero;
  assign PROTO_ERR = proto_err_reg;

endmodule

// File: tb/tb_bus_slave_fsm.sv
// ---------------------------------------------------------------------------
// tb_bus_slave_fsm
//   Three slaves on one clock: a memory device with 1 wait state (dut 0),
//   an I/O device with 3 wait states (dut 1) and a zero-wait memory device
//   (dut 2). Each has its own chip select and data bus; the data buses carry
//   pull-ups so a released bus reads 8'hFF.
// ---------------------------------------------------------------------------
module tb_bus_slave_fsm;

  localparam logic [7:0] REL = 8'hFF;  // value of a released (pulled-up) bus

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        cs_m = 1'b0, cs_io = 1'b0, cs_z = 1'b0;
  logic        ale = 1'b0, iom = 1'b1, rd = 1'b1, wr = 1'b1;
  logic [19:0] addr = 20'h0;
  logic        drv_en = 1'b0;
  int          drv_sel = 0;
  logic [7:0]  drv_val = 8'h00;

  tri1 [7:0]   data_m;
  tri1 [7:0]   data_io;
  tri1 [7:0]   data_z;
  logic        ready_m, ready_io, ready_z;
  logic        perr_m, perr_io, perr_z;

  int          checks = 0;
  int          passes = 0;

  assign data_m  = (drv_en && drv_sel == 0) ? drv_val : 8'hzz;
  assign data_io = (drv_en && drv_sel == 1) ? drv_val : 8'hzz;
  assign data_z  = (drv_en && drv_sel == 2) ? drv_val : 8'hzz;

  always #5 CLK = ~CLK;

  bus_slave_fsm #(.IO(0), .ADDR_BITS(8), .WAIT_STATES(1)) u_mem (
    .CLK(CLK), .RESET_N(RESET_N), .CS(cs_m), .ALE(ale), .IOM(iom), .RD(rd),
    .WR(wr), .Address(addr), .Data(data_m), .READY(ready_m), .PROTO_ERR(perr_m)
  );

  bus_slave_fsm #(.IO(1), .ADDR_BITS(8), .WAIT_STATES(3)) u_io (
    .CLK(CLK), .RESET_N(RESET_N), .CS(cs_io), .ALE(ale), .IOM(iom), .RD(rd),
    .WR(wr), .Address(addr), .Data(data_io), .READY(ready_io), .PROTO_ERR(perr_io)
  );

  bus_slave_fsm #(.IO(0), .ADDR_BITS(8), .WAIT_STATES(0)) u_zws (
    .CLK(CLK), .RESET_N(RESET_N), .CS(cs_z), .ALE(ale), .IOM(iom), .RD(rd),
    .WR(wr), .Address(addr), .Data(data_z), .READY(ready_z), .PROTO_ERR(perr_z)
  );

  typedef struct {
    int          dut;
    logic        ale;
    logic        iom;
    logic        rd;
    logic        wr;
    logic [19:0] addr;
    logic        drv;
    logic [7:0]  wdata;
    logic        exp_ready;
    logic        exp_perr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int d, logic a, logic io_m, logic r, logic w,
                              logic [19:0] ad, logic dv, logic [7:0] wd,
                              logic er, logic ep, logic [7:0] ed);
    vec_t v;
    v.dut = d; v.ale = a; v.iom = io_m; v.rd = r; v.wr = w; v.addr = ad;
    v.drv = dv; v.wdata = wd; v.exp_ready = er; v.exp_perr = ep; v.exp_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  // One bus cycle: drive at negedge, sample 1 ns after the following posedge.
  task automatic apply(input vec_t v, input int idx);
    logic       r;
    logic       p;
    logic [7:0] d;
    @(negedge CLK);
    cs_m    = (v.dut == 0);
    cs_io   = (v.dut == 1);
    cs_z    = (v.dut == 2);
    ale     = v.ale;
    iom     = v.iom;
    rd      = v.rd;
    wr      = v.wr;
    addr    = v.addr;
    drv_sel = v.dut;
    drv_en  = v.drv;
    drv_val = v.wdata;
    @(posedge CLK);
    #1;
    case (v.dut)
      0:       begin r = ready_m;  p = perr_m;  d = data_m;  end
      1:       begin r = ready_io; p = perr_io; d = data_io; end
      default: begin r = ready_z;  p = perr_z;  d = data_z;  end
    endcase
    $display("vec %0d dut %0d ale=%b iom=%b rd=%b wr=%b addr=%h | ready=%b perr=%b data=%h",
             idx, v.dut, v.ale, v.iom, v.rd, v.wr, v.addr, r, p, d);
    check($sformatf("vec%0d_ready", idx), {7'b0, r}, {7'b0, v.exp_ready});
    check($sformatf("vec%0d_perr", idx), {7'b0, p}, {7'b0, v.exp_perr});
    check($sformatf("vec%0d_data", idx), d, v.exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    // ---------------- dut 0: memory, 1 wait state ----------------
    // write A5 @ 80012: READY low exactly one cycle
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 1, 0, 20'h80012, 1, 8'hA5, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1, 0, 20'h80012, 1, 8'hA5, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1, 0, 20'h80012, 1, 8'hA5, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    // read it back
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    // wrap-around: write 3C at offset FF, read via 801FF
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h000FF, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 1, 0, 20'h000FF, 1, 8'h3C, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 1, 0, 20'h000FF, 1, 8'h3C, 1, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 1, 0, 20'h000FF, 1, 8'h3C, 1, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h000FF, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h801FF, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h801FF, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h801FF, 0, 8'h00, 1, 0, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h801FF, 0, 8'h00, 1, 0, REL));
    // RD and WR both low in ADDR: error pulse, nothing written
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 0, 20'h80012, 1, 8'h00, 1, 1, 8'h00));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 1, 0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    // RD released during WAIT: abort, READY back high, error pulse
    vecs.push_back(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 1, REL));
    vecs.push_back(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL));

    // ---------------- dut 1: I/O, 3 wait states ----------------
    vecs.push_back(mk(1, 1, 0, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(1, 0, 0, 1, 0, 20'h0FF04, 1, 8'h5A, 0, 0, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 1, 0, 20'h0FF04, 1, 8'h5A, 0, 0, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 1, 0, 20'h0FF04, 1, 8'h5A, 0, 0, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 1, 0, 20'h0FF04, 1, 8'h5A, 1, 0, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 1, 0, 20'h0FF04, 1, 8'h5A, 1, 0, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));
    // read: READY low three cycles, data on the 4th edge
    vecs.push_back(mk(1, 1, 0, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(1, 0, 0, 0, 1, 20'h0FF04, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(1, 0, 0, 0, 1, 20'h0FF04, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(1, 0, 0, 0, 1, 20'h0FF04, 0, 8'h00, 0, 0, REL));
    vecs.push_back(mk(1, 0, 0, 0, 1, 20'h0FF04, 0, 8'h00, 1, 0, 8'h5A));
    vecs.push_back(mk(1, 0, 0, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));
    // same access as a memory cycle: no response
    vecs.push_back(mk(1, 1, 1, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 0, 1, 0, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(1, 0, 1, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL));

    // ---------------- dut 2: memory, no wait states ----------------
    vecs.push_back(mk(2, 1, 1, 1, 1, 20'h00000, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 0, 1, 1, 0, 20'h00000, 1, 8'h11, 1, 0, 8'h11));
    vecs.push_back(mk(2, 0, 1, 1, 0, 20'h00000, 1, 8'h11, 1, 0, 8'h11));
    vecs.push_back(mk(2, 0, 1, 1, 1, 20'h00000, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 1, 1, 1, 1, 20'h00001, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 0, 1, 1, 0, 20'h00001, 1, 8'h22, 1, 0, 8'h22));
    vecs.push_back(mk(2, 0, 1, 1, 0, 20'h00001, 1, 8'h22, 1, 0, 8'h22));
    vecs.push_back(mk(2, 0, 1, 1, 1, 20'h00001, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 1, 1, 1, 1, 20'h00000, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 0, 1, 0, 1, 20'h00000, 0, 8'h00, 1, 0, 8'h11));
    vecs.push_back(mk(2, 0, 1, 1, 1, 20'h00000, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 1, 1, 1, 1, 20'h00001, 0, 8'h00, 1, 0, REL));
    vecs.push_back(mk(2, 0, 1, 0, 1, 20'h00001, 0, 8'h00, 1, 0, 8'h22));
    vecs.push_back(mk(2, 0, 1, 1, 1, 20'h00001, 0, 8'h00, 1, 0, REL));

    // ---------------- reset state ----------------
    repeat (2) @(negedge CLK);
    check("rst_ready_m", {7'b0, ready_m}, 8'h01);
    check("rst_ready_io", {7'b0, ready_io}, 8'h01);
    check("rst_ready_z", {7'b0, ready_z}, 8'h01);
    check("rst_perr_m", {7'b0, perr_m}, 8'h00);
    check("rst_perr_io", {7'b0, perr_io}, 8'h00);
    check("rst_perr_z", {7'b0, perr_z}, 8'h00);
    check("rst_data_m", data_m, REL);
    check("rst_data_io", data_io, REL);
    check("rst_data_z", data_z, REL);
    RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // ---------------- async reset while dut 0 is driving read data ----------------
    apply(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL), 1000);
    apply(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 0, 0, REL), 1001);
    apply(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 1, 0, 8'hA5), 1002);
    #2 RESET_N = 1'b0;       // between edges, RD still low
    #1;
    $display("async reset in RDATA: data_m=%h ready_m=%b", data_m, ready_m);
    check("rst_mid_read_data", data_m, REL);
    check("rst_mid_read_ready", {7'b0, ready_m}, 8'h01);
    @(negedge CLK);
    rd = 1'b1;
    RESET_N = 1'b1;

    // ---------------- async reset while dut 1 holds READY low ----------------
    apply(mk(1, 1, 0, 1, 1, 20'h0FF04, 0, 8'h00, 1, 0, REL), 1003);
    apply(mk(1, 0, 0, 0, 1, 20'h0FF04, 0, 8'h00, 0, 0, REL), 1004);
    #2 RESET_N = 1'b0;
    #1;
    $display("async reset in WAIT: ready_io=%b data_io=%h", ready_io, data_io);
    check("rst_mid_wait_ready", {7'b0, ready_io}, 8'h01);
    check("rst_mid_wait_data", data_io, REL);
    @(negedge CLK);
    rd = 1'b1;
    RESET_N = 1'b1;

    // storage survives reset
    apply(mk(0, 1, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL), 1005);
    apply(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 0, 0, REL), 1006);
    apply(mk(0, 0, 1, 0, 1, 20'h80012, 0, 8'h00, 1, 0, 8'hA5), 1007);
    apply(mk(0, 0, 1, 1, 1, 20'h80012, 0, 8'h00, 1, 0, REL), 1008);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bus_slave_fsm.md
Name: bus_slave_fsm

Overview:
- Cycle-accurate 8088 minimum-mode bus slave: one memory or I/O device on the demultiplexed bus, downstream of the 8282 address latch and 8286 transceiver.
- Decodes the bus cycle from ALE/IOM/RD/WR/CS, inserts a programmable number of wait states by pulling READY low, and services reads and writes to internal byte storage.
- Replaces purely combinational device models, so the processor's T1–T4/Tw sequencing is exercised.

Parameters:
- IO, 0, device type: 0 = memory (responds when IOM=1), 1 = I/O (responds when IOM=0).
- ADDR_BITS, 8, storage depth is 2**ADDR_BITS bytes, indexed by Address[ADDR_BITS-1:0].
- WAIT_STATES, 1, number of Tw cycles inserted per access (0..15).

Ports:
- CLK  input  1  bus clock, all sampling on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- CS  input  1  chip select from external decode, active high.
- ALE  input  1  address latch enable from CPU.
- IOM  input  1  1 = memory cycle, 0 = I/O cycle.
- RD  input  1  read strobe, active low.
- WR  input  1  write strobe, active low.
- Address  input  20  latched bus address.
- Data  inout  8  transceiver-side data bus; driven only during a read data phase, else 'z.
- READY  output  1  0 = insert wait state, 1 = ready.
- PROTO_ERR  output  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset (async, RESET_N=0): state IDLE, READY=1, Data released ('z) immediately, PROTO_ERR=0, wait counter 0. Storage contents are not cleared and are preserved across reset.
- Selection: a cycle is ours when ALE=1 and CS=1 and IOM==~IO, all sampled at posedge. On that edge, latch offset = Address[ADDR_BITS-1:0] and go to ADDR. Offsets wrap modulo 2**ADDR_BITS.
- FSM states: IDLE, ADDR, WAIT, RDATA, WDATA, DONE.
- IDLE: stay until a selecting ALE.
- ADDR:
  - RD=0, WR=1 -> load counter=WAIT_STATES, go to WAIT (or RDATA if WAIT_STATES=0).
  - WR=0, RD=1 -> same, with WDATA as the target.
  - RD=0 and WR=0 -> PROTO_ERR pulse, go to IDLE.
  - Both high -> stay.
  - ALE re-asserted -> re-latch.
- WAIT: READY=0 while counter>0; decrement each cycle. When counter reaches 0, READY returns to 1 in the same cycle the FSM moves to RDATA/WDATA. READY is registered: it changes only on posedge (or async reset).
- RDATA: drive Data = mem[offset] combinationally from the registered offset while state==RDATA and RD=0. When RD is sampled high, release Data and go to IDLE.
- WDATA: write mem[offset] <= Data on the first posedge in WDATA with WR=0, then go to DONE. If WR is already high on entry, no write occurs, PROTO_ERR pulses, and the FSM goes to IDLE.
- DONE: wait for WR sampled high, then go to IDLE.
- Strobe released early (RD/WR sampled high during WAIT): abort with no storage change, READY=1, PROTO_ERR pulse, go to IDLE.
- ALE sampled high in any state other than IDLE/ADDR: abort the current access (release Data, READY=1, PROTO_ERR pulse) and treat it as a new selection check on the same edge.
- Unselected cycles: READY stays 1 and Data stays 'z at all times.
- Latency with RD asserted at ADDR: data is on Data after WAIT_STATES+1 edges. With WAIT_STATES=0, READY is never deasserted.

Decomposition:
- Shared package bus8088_pkg holds:
  - typedef enum logic [2:0] bus_state_t {IDLE, ADDR, WAIT, RDATA, WDATA, DONE};
  - constants MEM_DEV=0 and IO_DEV=1;
  - typedef logic [19:0] addr20_t.
- One natural sub-module, wait_state_counter: loadable 4-bit down-counter with a zero flag, driving READY.
- Storage stays inline as an unpacked byte array.

Test Plan:
- Memory write then read, IO=0, WAIT_STATES=1:
  - Write 8'hA5 at 20'h80012 -> READY low for exactly 1 cycle, mem[8'h12]=8'hA5.
  - Read the same address -> Data=8'hA5 during RD low, 'z afterwards.
- I/O device, IO=1, WAIT_STATES=3, IOM=0 read of port 16'hFF04 -> READY low for 3 consecutive cycles, data valid on the 4th edge. The same access with IOM=1 -> no response, READY=1, Data='z.
- Wrap-around: ADDR_BITS=8, write 8'h3C at offset 8'hFF, then read at Address 20'h801FF -> returns 8'h3C.
- Protocol errors: RD and WR both low in ADDR -> PROTO_ERR 1-cycle pulse, no write. RD released during WAIT -> abort, READY=1 next edge.
- Reset mid-read: assert RESET_N=0 during RDATA, asynchronously between clock edges -> Data goes 'z and READY=1 without waiting for a clock edge; a read after reset returns the previously written value.
- WAIT_STATES=0 back-to-back reads of offsets 0 and 1 -> READY never low, correct bytes returned each cycle.
